// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the shared memory.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          gnt0;
   logic          rvalid0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          gnt1;
   logic          rvalid1;

   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
      output gnt0, rvalid0, gnt1, rvalid1, rdata, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
      input  gnt0, rvalid0, gnt1, rvalid1, rdata, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single synchronous memory: registered grants,
// round-robin on contention, and a per-grant burst limit while the other port waits.
module mem_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned BURST_MAX = 8
) (
  input logic           Clock,
  input logic           Resetn,
  mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

   localparam logic [7:0] CntLimit = 8'(BURST_MAX - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       last_q, last_d;
   logic       rvalid0_q, rvalid0_d;
   logic       rvalid1_q, rvalid1_d;
   logic       beat0, beat1, limit;

   assign beat0 = (state_q == StG0) & bus.req0;
   assign beat1 = (state_q == StG1) & bus.req1;
   // >= so a grant that ran long uncontended still yields on the next beat once the
   // other port starts requesting.
   assign limit = (cnt_q >= CntLimit);

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         last_q    <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         StIdle: begin
            if (bus.req0 && bus.req1) state_d = last_q ? StG0 : StG1;
            else if (bus.req0)        state_d = StG0;
            else if (bus.req1)        state_d = StG1;
         end
         StG0: begin
            if (!bus.req0) begin
               state_d = bus.req1 ? StG1 : StIdle;
               last_d  = 1'b0;
            end else if (limit && bus.req1) begin
               state_d = StG1;
               last_d  = 1'b0;
            end
         end
         StG1: begin
            if (!bus.req1) begin
               state_d = bus.req0 ? StG0 : StIdle;
               last_d  = 1'b1;
            end else if (limit && bus.req0) begin
               state_d = StG0;
               last_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q)                cnt_d = 8'd0;
      else if ((beat0 | beat1) && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      else                                   cnt_d = cnt_q;

      // Read valid is tagged by the issuing port so it survives a handover.
      rvalid0_d = beat0 & ~bus.we0;
      rvalid1_d = beat1 & ~bus.we1;
   end

   always_comb begin
      bus.gnt0      = (state_q == StG0);
      bus.gnt1      = (state_q == StG1);
      bus.rvalid0   = rvalid0_q;
      bus.rvalid1   = rvalid1_q;
      bus.rdata     = bus.mem_rdata;
      bus.mem_we    = (beat0 & bus.we0) | (beat1 & bus.we1);
      bus.mem_addr  = {AW{1'b0}};
      bus.mem_wdata = {DW{1'b0}};
      case (state_q)
         StG0: begin
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
         end
         StG1: begin
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single synchronous on-chip memory between the processor (port 0) and a secondary master such as a program loader or DMA engine (port 1).
- Registered grants, round-robin on contention, and a per-grant burst limit for fairness.
- Muxes address, write data and write enable to memory, and returns read data with a per-port valid one cycle after each read beat.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- BURST_MAX, 8, maximum beats per grant while the other port is requesting; legal range 1..255.

Ports:
- Clock  in  1  system clock, all state on posedge.
- Resetn  in  1  reset, synchronous, active-low.
- req0  in  1  port 0 request, held high for each beat wanted.
- we0  in  1  port 0 write (1) / read (0) for the current beat.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 owns memory (registered).
- rvalid0  out  1  rdata holds port 0 read data this cycle.
- req1, we1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1.
- rdata  out  DW  read data, driven straight from mem_rdata.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DW  memory read data, valid one cycle after its address is presented.

Behaviour:
- Reset (Resetn=0 at a posedge): state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, beat count=0, last-served=1 (so port 0 wins first). Outputs in IDLE: mem_addr=0, mem_wdata=0, mem_we=0.
- Reset mid-burst: any pending rvalid is discarded. No beat is issued in the cycle after reset.
- States are IDLE, G0 and G1. gnt0 = (state==G0) and gnt1 = (state==G1); both come from flops, so they are never high together.
- IDLE transitions:
  - Only req0 high: go to G0.
  - Only req1 high: go to G1.
  - Both high: go to the port that is not last-served.
  - Neither high: stay in IDLE.
  - Grant latency: request seen at edge t, grant high from cycle t+1.
- Beat: any cycle with gntN=1 and reqN=1.
  - During a beat: mem_addr=addrN, mem_wdata=wdataN, mem_we=weN.
  - Granted but reqN=0: mem_we=0, and mem_addr/mem_wdata keep the granted port's inputs (no transfer).
- Read return:
  - A read beat on port N at cycle t sets rvalidN=1 in cycle t+1, with rdata=mem_rdata.
  - Valid is tagged by the issuing port, so the last read beat of a grant still returns on the correct rvalid after the handover.
  - Back-to-back reads give continuous rvalid.
  - A write beat produces no rvalid.
- Beat count: cleared on grant entry; incremented on each beat, saturating at 255.
- Release from GN:
  - reqN=0 at an edge: next state is G(other) if the other port is requesting, else IDLE. last-served=N.
  - Preemption: a beat occurs with count==BURST_MAX-1 while the other port is requesting. Next state is G(other), last-served=N, and the count is cleared.
  - If the other port is not requesting, the burst limit is ignored and GN is held.
- Direct handover G0->G1 or G1->G0 happens in one edge with no IDLE bubble.
- Masters must keep we/addr/wdata stable only in beat cycles. Inputs outside a grant are ignored.

Test Plan:
- Single read:
  - Stimulus: after reset, req0=1, we0=0, addr0=0x0010 for one cycle; memory holds 0xBEEF at 0x0010.
  - Response: gnt0 high in the next cycle with mem_addr=0x0010; one cycle later rvalid0=1 and rdata=0xBEEF; rvalid1 stays 0.
- Tie after reset:
  - Stimulus: req0=req1=1 from cycle 0, both reads.
  - Response: G0 first; after 8 port-0 beats, G1 for 8 beats, then G0 again; gnt0 and gnt1 never high together.
- Write then read:
  - Stimulus: port 1 writes 0x1234 to 0x0040 (we1=1), then reads 0x0040.
  - Response: mem_we=1 for exactly one cycle with mem_addr=0x0040 and mem_wdata=0x1234; the read returns rvalid1=1 with rdata=0x1234.
- Uncontended burst:
  - Stimulus: req0 high for 20 beats, req1=0.
  - Response: gnt0 held for all 20 beats with no preemption; then req1 rises.
  - Response: after at most BURST_MAX beats gnt1=1, with a one-edge handover.
- Handover read tag:
  - Stimulus: port 0 read on its preempted last beat.
  - Response: rvalid0=1 in the first cycle of gnt1; no rvalid1 in that cycle.
- Reset mid-burst:
  - Stimulus: assert Resetn=0 during a G1 read burst.
  - Response: next cycle gnt1=0, rvalid1=0, mem_we=0, mem_addr=0; after release with req0=req1=1, port 0 is granted first.
